// File: rtl/bcd_display_driver.sv
// bcd_display_driver: registers a 0..99 binary count, converts it to two BCD
// digits with a sequential shift-add-3 FSM, and scans them onto a 2-digit
// multiplexed 7-segment display. Values >= CMAX are shown as dashes.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank a leading "0" tens digit).
module bcd_display_driver #(
    parameter int unsigned CMAX           = 100,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] count,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       ovf,
    output logic       busy,
    output logic [1:0] an,
    output logic [6:0] seg
);

    localparam int unsigned PW        = $clog2(SCAN_DIV);
    localparam logic [6:0]  SEG_ZERO  = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [6:0]    r_count_q;
    logic [6:0]    r_last_value, w_last_value_nxt;
    logic [6:0]    r_bin, w_bin_nxt;
    logic [7:0]    r_bcd, w_bcd_nxt;
    logic [2:0]    r_iter, w_iter_nxt;
    logic [3:0]    r_tens, w_tens_nxt;
    logic [3:0]    r_units, w_units_nxt;
    logic          r_ovf, w_ovf_nxt;
    logic          r_busy, w_busy_nxt;
    logic [PW-1:0] r_presc;
    logic          r_digit_sel;
    logic [1:0]    r_an;
    logic [6:0]    r_seg;
    logic [7:0]    w_bcd_adj;
    logic          w_is_ovf;
    logic          w_presc_wrap;
    logic [6:0]    w_seg_raw;

    // Active-low glyph table; unknown nibbles render fully dark.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    assign w_bcd_adj[7:4] = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
    assign w_bcd_adj[3:0] = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    assign w_is_ovf       = ({25'd0, r_last_value} >= CMAX);
    assign w_presc_wrap   = (r_presc == PW'(SCAN_DIV - 1));

    // Conversion FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_count_q    <= '0;
            r_last_value <= '0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_iter       <= '0;
            r_tens       <= '0;
            r_units      <= '0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count_q    <= count;
            r_last_value <= w_last_value_nxt;
            r_bin        <= w_bin_nxt;
            r_bcd        <= w_bcd_nxt;
            r_iter       <= w_iter_nxt;
            r_tens       <= w_tens_nxt;
            r_units      <= w_units_nxt;
            r_ovf        <= w_ovf_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state logic: capture on change, 7 adjust-then-shift steps, atomic publish.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_value_nxt = r_last_value;
        w_bin_nxt        = r_bin;
        w_bcd_nxt        = r_bcd;
        w_iter_nxt       = r_iter;
        w_tens_nxt       = r_tens;
        w_units_nxt      = r_units;
        w_ovf_nxt        = r_ovf;
        w_busy_nxt       = r_busy;
        case (r_state)
            S_IDLE: begin
                if (r_count_q != r_last_value) begin
                    w_bin_nxt        = r_count_q;
                    w_last_value_nxt = r_count_q;
                    w_bcd_nxt        = '0;
                    w_iter_nxt       = '0;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {w_bcd_nxt, w_bin_nxt} = {w_bcd_adj, r_bin} << 1;
                w_iter_nxt = r_iter + 3'd1;
                if (r_iter == 3'd6) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // r_last_value still holds the captured value for this conversion.
                if (w_is_ovf) begin
                    w_tens_nxt  = 4'hF;
                    w_units_nxt = 4'hF;
                    w_ovf_nxt   = 1'b1;
                end else begin
                    w_tens_nxt  = r_bcd[7:4];
                    w_units_nxt = r_bcd[3:0];
                    w_ovf_nxt   = 1'b0;
                end
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Scan prescaler; digit select toggles on each wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc     <= '0;
            r_digit_sel <= 1'b0;
        end else if (w_presc_wrap) begin
            r_presc     <= '0;
            r_digit_sel <= ~r_digit_sel;
        end else begin
            r_presc     <= r_presc + PW'(1);
        end
    end

    // Segment pattern for the currently selected digit (active-low form).
    always_comb begin
        w_seg_raw = 7'b1111111;
        if (r_ovf) begin
            w_seg_raw = 7'b0111111;
        end else if (r_digit_sel) begin
`ifdef LEADING_ZERO_BLANK_EN
            w_seg_raw = (r_tens == 4'd0) ? 7'b1111111 : glyph(r_tens);
`else
            w_seg_raw = glyph(r_tens);
`endif
        end else begin
            w_seg_raw = glyph(r_units);
        end
    end

    // Registered display pins (one cycle behind digit select).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= 2'b10;
            r_seg <= SEG_ZERO;
        end else begin
            r_an  <= r_digit_sel ? 2'b01 : 2'b10;
            r_seg <= SEG_ACTIVE_LOW ? w_seg_raw : ~w_seg_raw;
        end
    end

    assign tens  = r_tens;
    assign units = r_units;
    assign ovf   = r_ovf;
    assign busy  = r_busy;
    assign an    = r_an;
    assign seg   = r_seg;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed testbench for bcd_display_driver (CMAX=100, SCAN_DIV=4, active-low segments).
module tb_bcd_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] count;
    logic [3:0] tens, units;
    logic       ovf, busy;
    logic [1:0] an;
    logic [6:0] seg;

    int n_checks = 0;
    int n_errors = 0;

    bcd_display_driver #(
        .CMAX          (100),
        .SCAN_DIV      (4),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .count(count),
        .tens (tens),
        .units(units),
        .ovf  (ovf),
        .busy (busy),
        .an   (an),
        .seg  (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new value and check the 9-cycle latency and the published result.
    task automatic conv(input logic [6:0] v, input logic [3:0] et, input logic [3:0] eu,
                        input logic eo, input logic [3:0] pt, input logic [3:0] pu);
        count = v;
        tick();                                   // E0
        check("busy_e0", busy, 1'b0);
        tick();                                   // E1
        check("busy_e1", busy, 1'b1);
        repeat (6) tick();                        // E2..E7
        tick();                                   // E8
        check("busy_e8", busy, 1'b1);
        check("hold_e8", {tens, units}, {pt, pu});
        tick();                                   // E9
        check("busy_e9", busy, 1'b0);
        check("tens", tens, et);
        check("units", units, eu);
        check("ovf", ovf, eo);
    endtask

    // Observe the scan for 16 cycles: slot patterns and a 4-clock toggle period.
    task automatic scan_check(input logic [6:0] seg_u, input logic [6:0] seg_t);
        int         last_chg = -1;
        int         n_chg    = 0;
        logic [1:0] prev_an  = an;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (an == 2'b10)      check("seg_units_slot", seg, seg_u);
            else if (an == 2'b01) check("seg_tens_slot", seg, seg_t);
            else                  check("an_onehot", an, 2'b10);
            if (an != prev_an) begin
                if (last_chg >= 0) check("scan_period", i - last_chg, 4);
                last_chg = i;
                n_chg++;
                prev_an = an;
            end
        end
        check("scan_toggles", (n_chg >= 3), 1'b1);
    endtask

    initial begin
        int         bad;
        bit         seen37;
        bit         busy_seen;
        logic [7:0] pair;

        // Reset state
        rst   = 1'b0;
        count = 7'd0;
        repeat (3) tick();
        check("rst_tens", tens, 4'd0);
        check("rst_units", units, 4'd0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_an", an, 2'b10);
        check("rst_seg", seg, 7'b1000000);
        rst = 1'b1;
        busy_seen = 1'b0;
        repeat (12) begin
            tick();
            if (busy) busy_seen = 1'b1;
        end
        check("no_busy_after_rst", busy_seen, 1'b0);

        // Latency and boundary values
        conv(7'd37,  4'd3, 4'd7, 1'b0, 4'd0, 4'd0);
        conv(7'd99,  4'd9, 4'd9, 1'b0, 4'd3, 4'd7);
        conv(7'd0,   4'd0, 4'd0, 1'b0, 4'd9, 4'd9);
        conv(7'd1,   4'd0, 4'd1, 1'b0, 4'd0, 4'd0);

        // Overflow shows dashes in both slots, then recovers
        conv(7'd100, 4'hF, 4'hF, 1'b1, 4'd0, 4'd1);
        repeat (2) tick();
        scan_check(7'b0111111, 7'b0111111);
        conv(7'd42,  4'd4, 4'd2, 1'b0, 4'hF, 4'hF);

        // Mid-conversion change: only 42, 37, 52 may ever appear, in that order
        bad    = 0;
        seen37 = 1'b0;
        count  = 7'd37;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 2) count = 7'd52;
            pair = {tens, units};
            if (pair == 8'h37) seen37 = 1'b1;
            else if (pair == 8'h52) begin
                if (!seen37) bad++;
            end else if (pair != 8'h42) bad++;
        end
        check("mid_no_glitch", bad, 0);
        check("mid_saw_37", seen37, 1'b1);
        check("mid_final", {tens, units}, 8'h52);
        check("mid_idle", busy, 1'b0);

        // Scan of 37
        conv(7'd37, 4'd3, 4'd7, 1'b0, 4'd5, 4'd2);
        repeat (2) tick();
        scan_check(7'b1111000, 7'b0110000);

        // Leading-zero tens slot
        conv(7'd5, 4'd0, 4'd5, 1'b0, 4'd3, 4'd7);
        repeat (2) tick();
`ifdef LEADING_ZERO_BLANK_EN
        scan_check(7'b0010010, 7'b1111111);
`else
        scan_check(7'b0010010, 7'b1000000);
`endif

        // Reset mid-conversion, then reconversion of the pending value
        count = 7'd77;
        repeat (4) tick();
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_digits", {tens, units}, 8'h00);
        check("midrst_an", an, 2'b10);
        check("midrst_seg", seg, 7'b1000000);
        tick();
        rst = 1'b1;
        repeat (12) tick();
        check("reconv_digits", {tens, units}, 8'h77);
        check("reconv_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_driver.md
Name: bcd_display_driver

Overview:
- Consumer end of the 0–99 counter datapath: samples the 7-bit binary `count` and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Drives a 2-digit time-multiplexed 7-segment display.
- Sits between the counter and the board's display pins; flags out-of-range values instead of showing garbage.

Parameters:
- CMAX, 100, first illegal value; count >= CMAX is overflow; legal range 1..100.
- SCAN_DIV, 50000, clocks per digit-scan slot; minimum 2.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when 0; 0 = lit when 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- count  input  7  binary value from the counter.
- tens  output  4  BCD tens digit (4'hF on overflow).
- units  output  4  BCD units digit (4'hF on overflow).
- ovf  output  1  high while displayed value came from count >= CMAX.
- busy  output  1  high while a conversion is in progress.
- an  output  2  digit enables, active-low, one-hot-zero; an[0] = units, an[1] = tens.
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW.

Behaviour:
- Reset (rst=0, async): tens=0, units=0, ovf=0, busy=0, FSM=IDLE, digit_sel=units, prescaler=0, an=2'b10, seg=glyph "0" (7'b1000000 when SEG_ACTIVE_LOW=1). last_value is set to 0, so no conversion starts after reset unless count != 0.
- Input stage: count is registered every clock into count_q.
- IDLE:
  - If count_q != last_value: capture count_q into the shift register and into last_value, clear the BCD accumulator, busy=1, go to SHIFT with iteration counter=0.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each clock: add 3 to every BCD nibble that is >= 5, then shift {bcd, bin} left by one.
  - After exactly 7 iterations go to DONE.
- DONE (one clock): update tens/units/ovf atomically, busy=0, return to IDLE.
  - Overflow: if the captured value >= CMAX, tens=units=4'hF and ovf=1.
  - Otherwise write the BCD result and set ovf=0.
- Latency: count stable before edge E0 → count_q at E0 → busy=1 after E1 → seven shifts on E2..E8 → tens/units/ovf valid and busy=0 after E9.
- count changing mid-conversion: no abort. The current result completes; the new value is detected in the next IDLE and converted then. tens/units never show a partial result.
- Scan prescaler counts 0..SCAN_DIV-1 and wraps. On wrap, digit_sel toggles.
- an and seg are registered every clock from the current digit_sel and tens/units/ovf, giving a 1-cycle lag.
- Glyphs (active-low form; invert all when SEG_ACTIVE_LOW=0):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash (ovf) = 0111111
  - any other nibble = all off (1111111)
- rst asserted mid-conversion: returns immediately to reset values; the pending value is reconverted after release if count != 0.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when the tens slot is selected, tens==0 and ovf==0, seg = all segments off (7'b1111111 active-low); an still strobes normally.
- Undefined: the tens digit always shows its glyph, including "0".

Test Plan:
- Reset: hold rst=0 with count=0 → tens=0, units=0, ovf=0, busy=0, an=2'b10, seg=7'b1000000; no busy pulse after release.
- Conversion latency: count=37 → busy high after E1 → tens=3, units=7, busy=0 exactly after E9; never earlier.
- Boundaries: count=99 → 9/9; then count=0 → 0/0; then count=1 → 0/1; each conversion takes 9 cycles.
- Overflow: count=100 with CMAX=100 → ovf=1, tens=units=4'hF, both scan slots seg=7'b0111111; then count=42 → ovf=0, 4/2.
- Mid-conversion change: count=37, then count=52 three cycles later → tens/units go to 3/7, then to 5/2; no other intermediate values observed.
- Scan with SCAN_DIV=4 and count=37:
  - an alternates 2'b10/2'b01 every 4 clocks.
  - seg=7'b1111000 in the units slot and 7'b0110000 in the tens slot.
  - With LEADING_ZERO_BLANK_EN and count=5: tens slot seg=7'b1111111, units slot seg=7'b0010010.
